pwm_capture: RTL and testbench

- Measures the gate signals of one half bridge, driven by the existing PWM generator or by external hardware.
- Recovers the per-period tick counts: highside on-time, hs→ls deadtime, lowside on-time, ls→hs deadtime and total period.
- Used for closed-loop verification of gate timing, for monitoring, and for shoot-through and stall detection.
- Sits beside the PWM generator in the same clock domain. Gate inputs are treated as asynchronous.

---
 rtl/pwm_capture_if.sv | 33 +++
 rtl/pwm_capture.sv | 189 ++++++++++++++++++
 tb/tb_pwm_capture.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// Gate inputs, fault clear and measurement outputs of one half-bridge capture unit.
// The slave side is the capture block; the master side drives the gates and reads the counts.
interface pwm_capture_if #(
    parameter int bitwidth = 11
) ();
    logic                highside_input;
    logic                lowside_input;
    logic                fault_clear;
    logic [bitwidth-1:0] tick_count_highside_output;
    logic [bitwidth-1:0] deadtime_hs_to_ls_output;
    logic [bitwidth-1:0] tick_count_lowside_output;
    logic [bitwidth-1:0] deadtime_ls_to_hs_output;
    logic [bitwidth-1:0] tick_count_period_output;
    logic                measurement_valid;
    logic                shoot_through_fault;
    logic                stalled;

    modport master (
        output highside_input, lowside_input, fault_clear,
        input  tick_count_highside_output, deadtime_hs_to_ls_output,
               tick_count_lowside_output, deadtime_ls_to_hs_output,
               tick_count_period_output, measurement_valid,
               shoot_through_fault, stalled
    );

    modport slave (
        input  highside_input, lowside_input, fault_clear,
        output tick_count_highside_output, deadtime_hs_to_ls_output,
               tick_count_lowside_output, deadtime_ls_to_hs_output,
               tick_count_period_output, measurement_valid,
               shoot_through_fault, stalled
    );
endinterface

// File: rtl/pwm_capture.sv
// Half-bridge gate timing capture: recovers on-times, deadtimes and period from the
// two gate signals, and flags shoot-through and stalled gates.
module pwm_capture #(
    parameter int tick_count_max = 1023,
    parameter int bitwidth       = $clog2(tick_count_max) + 1,
    parameter int timeout_ticks  = 1000
) (
    input  logic         clock,
    input  logic         reset,
    pwm_capture_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HS_ON, DEAD_HL, LS_ON, DEAD_LH} state_t;
    typedef logic [bitwidth-1:0] count_t;

    localparam count_t            count_max = count_t'(tick_count_max);
    localparam int                idle_w    = $clog2(timeout_ticks + 1);
    localparam logic [idle_w-1:0] idle_max  = idle_w'(timeout_ticks);
    localparam logic [idle_w-1:0] idle_last = idle_w'(timeout_ticks - 1);

    function automatic count_t sat_inc(input count_t v);
        return (v == count_max) ? v : v + count_t'(1);
    endfunction

    logic hs_meta, hs_sync, hs_prev;
    logic ls_meta, ls_sync, ls_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {hs_meta, hs_sync, hs_prev} <= '0;
            {ls_meta, ls_sync, ls_prev} <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous stage's old value, so the chain shifts one flop per clock.
            hs_meta <= bus.highside_input;
            hs_sync <= hs_meta;
            hs_prev <= hs_sync;
            ls_meta <= bus.lowside_input;
            ls_sync <= ls_meta;
            ls_prev <= ls_sync;
        end
    end

    logic hs_rise, hs_fall, ls_rise, ls_fall, any_edge, overlap, stall_hit;
    logic [idle_w-1:0] idle_cnt;

    assign hs_rise   = hs_sync & ~hs_prev;
    assign hs_fall   = ~hs_sync & hs_prev;
    assign ls_rise   = ls_sync & ~ls_prev;
    assign ls_fall   = ~ls_sync & ls_prev;
    assign any_edge  = hs_rise | hs_fall | ls_rise | ls_fall;
    assign overlap   = hs_sync & ls_sync;
    assign stall_hit = (idle_cnt == idle_last) & ~any_edge;

    count_t seg_cnt, per_cnt;

    // Counters restart at 1 so a value latched in a detection cycle equals the cycle distance between edges.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_cnt  <= '0;
            per_cnt  <= '0;
            idle_cnt <= '0;
        end else begin
            seg_cnt <= any_edge ? count_t'(1) : sat_inc(seg_cnt);
            per_cnt <= hs_rise  ? count_t'(1) : sat_inc(per_cnt);
            if (any_edge)
                idle_cnt <= '0;
            else if (idle_cnt != idle_max)
                idle_cnt <= idle_cnt + 1'b1;
        end
    end

    state_t state_q, state_d;
    count_t hs_seg_q, dhl_q, ls_seg_q;
    count_t hs_seg_d, dhl_d, ls_seg_d, dlh_fin;
    logic   complete;

    always_comb begin
        // NOTE: every signal written here is defaulted first so no path leaves one unassigned and infers a latch.
        state_d  = state_q;
        hs_seg_d = hs_seg_q;
        dhl_d    = dhl_q;
        ls_seg_d = ls_seg_q;
        dlh_fin  = '0;
        complete = 1'b0;
        case (state_q)
            IDLE: if (hs_rise) state_d = HS_ON;
            HS_ON: begin
                if (hs_fall) begin
                    hs_seg_d = seg_cnt;
                    if (ls_rise) begin
                        dhl_d   = '0;
                        state_d = LS_ON;
                    end else begin
                        state_d = DEAD_HL;
                    end
                end else if (any_edge) begin
                    state_d = IDLE;
                end
            end
            DEAD_HL: begin
                if (ls_rise && !hs_rise) begin
                    dhl_d   = seg_cnt;
                    state_d = LS_ON;
                end else if (hs_rise && !ls_rise) begin
                    dhl_d    = seg_cnt;
                    ls_seg_d = '0;
                    complete = 1'b1;
                    state_d  = HS_ON;
                end else if (any_edge) begin
                    state_d = IDLE;
                end
            end
            LS_ON: begin
                if (ls_fall) begin
                    ls_seg_d = seg_cnt;
                    if (hs_rise) begin
                        complete = 1'b1;
                        state_d  = HS_ON;
                    end else begin
                        state_d = DEAD_LH;
                    end
                end else if (any_edge) begin
                    state_d = IDLE;
                end
            end
            DEAD_LH: begin
                if (hs_rise && !ls_rise) begin
                    dlh_fin  = seg_cnt;
                    complete = 1'b1;
                    state_d  = HS_ON;
                end else if (any_edge) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (overlap || stall_hit) begin
            state_d  = IDLE;
            complete = 1'b0;
        end
    end

    count_t hs_out, dhl_out, ls_out, dlh_out, per_out;
    logic   valid_q, fault_q, stalled_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            hs_seg_q  <= '0;
            dhl_q     <= '0;
            ls_seg_q  <= '0;
            hs_out    <= '0;
            dhl_out   <= '0;
            ls_out    <= '0;
            dlh_out   <= '0;
            per_out   <= '0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hs_seg_q <= hs_seg_d;
            dhl_q    <= dhl_d;
            ls_seg_q <= ls_seg_d;
            valid_q  <= complete;
            if (complete) begin
                hs_out  <= hs_seg_d;
                dhl_out <= dhl_d;
                ls_out  <= ls_seg_d;
                dlh_out <= dlh_fin;
                per_out <= per_cnt;
            end
            // A new overlap wins over a coincident clear.
            fault_q <= overlap | (fault_q & ~bus.fault_clear);
            if (any_edge)
                stalled_q <= 1'b0;
            else if (stall_hit)
                stalled_q <= 1'b1;
        end
    end

    assign bus.tick_count_highside_output = hs_out;
    assign bus.deadtime_hs_to_ls_output   = dhl_out;
    assign bus.tick_count_lowside_output  = ls_out;
    assign bus.deadtime_ls_to_hs_output   = dlh_out;
    assign bus.tick_count_period_output   = per_out;
    assign bus.measurement_valid          = valid_q;
    assign bus.shoot_through_fault        = fault_q;
    assign bus.stalled                    = stalled_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Directed and randomized gate waveforms against a period-level model of the expected
// measurements; a second instance with a long timeout exercises count saturation.
module tb_pwm_capture;
    localparam int cmax = 1023;

    typedef struct { int th; int dhl; int tl; int dlh; } per_t;
    typedef struct { int hs; int dhl; int ls; int dlh; int per; } meas_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hs  = 1'b0;
    logic ls  = 1'b0;
    logic fc  = 1'b0;

    always #5 clk = ~clk;

    pwm_capture_if #(.bitwidth(11)) ifa ();
    pwm_capture_if #(.bitwidth(11)) ifb ();

    assign ifa.highside_input = hs;
    assign ifa.lowside_input  = ls;
    assign ifa.fault_clear    = fc;
    assign ifb.highside_input = hs;
    assign ifb.lowside_input  = ls;
    assign ifb.fault_clear    = fc;

    pwm_capture u_a (.clock(clk), .reset(rst), .bus(ifa.slave));
    pwm_capture #(.timeout_ticks(4000)) u_b (.clock(clk), .reset(rst), .bus(ifb.slave));

    meas_t qa[$], qb[$], ea[$], eb[$];
    int n_checks = 0;
    int n_pass   = 0;

    always @(negedge clk) begin
        if (ifa.measurement_valid)
            qa.push_back('{hs: int'(ifa.tick_count_highside_output), dhl: int'(ifa.deadtime_hs_to_ls_output),
                           ls: int'(ifa.tick_count_lowside_output), dlh: int'(ifa.deadtime_ls_to_hs_output),
                           per: int'(ifa.tick_count_period_output)});
        if (ifb.measurement_valid)
            qb.push_back('{hs: int'(ifb.tick_count_highside_output), dhl: int'(ifb.deadtime_hs_to_ls_output),
                           ls: int'(ifb.tick_count_lowside_output), dlh: int'(ifb.deadtime_ls_to_hs_output),
                           per: int'(ifb.tick_count_period_output)});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int sat(input int v);
        return (v > cmax) ? cmax : v;
    endfunction

    // Expected report for one driven period; a period with no lowside pulse is DCM.
    function automatic meas_t model(input per_t p);
        meas_t m;
        bit dcm = (p.tl == 0);
        m.hs  = sat(p.th);
        m.dhl = sat(p.dhl);
        m.ls  = sat(p.tl);
        m.dlh = dcm ? 0 : sat(p.dlh);
        m.per = sat(p.th + p.dhl + p.tl + (dcm ? 0 : p.dlh));
        return m;
    endfunction

    task automatic drive(input logic h, input logic l, input int n);
        hs = h;
        ls = l;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_period(input per_t p);
        drive(1'b1, 1'b0, p.th);
        drive(1'b0, 1'b0, p.dhl);
        if (p.tl != 0) begin
            drive(1'b0, 1'b1, p.tl);
            drive(1'b0, 1'b0, p.dlh);
        end
    endtask

    // Drives the periods back to back; each rise after the first completes the previous one.
    task automatic run_list(input per_t ps[$]);
        for (int i = 0; i < ps.size(); i++) begin
            drive_period(ps[i]);
            if (i > 0) begin
                ea.push_back(model(ps[i-1]));
                eb.push_back(model(ps[i-1]));
            end
        end
        drive(1'b0, 1'b0, 5);
    endtask

    task automatic clear_queues();
        qa.delete(); qb.delete(); ea.delete(); eb.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hs  = 1'b0;
        ls  = 1'b0;
        fc  = 1'b0;
        repeat (2) @(negedge clk);
        clear_queues();
        rst = 1'b0;
        drive(1'b0, 1'b0, 5);
    endtask

    task automatic compare(input string tag, input bit use_b);
        meas_t g[$], e[$];
        g = use_b ? qb : qa;
        e = use_b ? eb : ea;
        check($sformatf("%s_count", tag), g.size(), e.size());
        for (int i = 0; i < g.size() && i < e.size(); i++) begin
            check($sformatf("%s_%0d_hs", tag, i),  g[i].hs,  e[i].hs);
            check($sformatf("%s_%0d_dhl", tag, i), g[i].dhl, e[i].dhl);
            check($sformatf("%s_%0d_ls", tag, i),  g[i].ls,  e[i].ls);
            check($sformatf("%s_%0d_dlh", tag, i), g[i].dlh, e[i].dlh);
            check($sformatf("%s_%0d_per", tag, i), g[i].per, e[i].per);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_hs"},    ifa.tick_count_highside_output, 0);
        check({tag, "_dhl"},   ifa.deadtime_hs_to_ls_output, 0);
        check({tag, "_ls"},    ifa.tick_count_lowside_output, 0);
        check({tag, "_dlh"},   ifa.deadtime_ls_to_hs_output, 0);
        check({tag, "_per"},   ifa.tick_count_period_output, 0);
        check({tag, "_valid"}, ifa.measurement_valid, 0);
    endtask

    initial begin
        per_t  ps[$];
        per_t  p, n1, n2, n3, n4, satp;
        meas_t m1;

        // Reset state
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        check("reset_fault", ifa.shoot_through_fault, 0);
        check("reset_stalled", ifa.stalled, 0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 5);

        // Complementary PWM, three periods -> two reports
        ps = '{'{30, 12, 40, 18}, '{30, 12, 40, 18}, '{30, 12, 40, 18}};
        run_list(ps);
        compare("comp", 1'b0);
        check("comp_fault", ifa.shoot_through_fault, 0);

        // DCM: lowside never switches on
        do_reset();
        ps = '{'{25, 75, 0, 0}, '{25, 75, 0, 0}, '{25, 75, 0, 0}};
        run_list(ps);
        compare("dcm", 1'b0);

        // Zero deadtime on both transitions
        do_reset();
        ps = '{'{50, 0, 50, 0}, '{50, 0, 50, 0}, '{50, 0, 50, 0}};
        run_list(ps);
        compare("zero_dt", 1'b0);
        check("zero_dt_fault", ifa.shoot_through_fault, 0);

        // Randomized periods, including DCM and zero deadtimes
        do_reset();
        ps.delete();
        for (int i = 0; i < 10; i++) begin
            p.th = int'($urandom_range(2, 80));
            if ($urandom_range(0, 3) == 0) begin
                p.dhl = int'($urandom_range(1, 30));
                p.tl  = 0;
                p.dlh = 0;
            end else begin
                p.dhl = int'($urandom_range(0, 20));
                p.tl  = int'($urandom_range(2, 80));
                p.dlh = int'($urandom_range(0, 20));
            end
            ps.push_back(p);
        end
        run_list(ps);
        compare("rand", 1'b0);

        // Shoot-through: overlapping period is discarded, fault is sticky
        do_reset();
        n1 = '{20, 5, 20, 5};
        n2 = '{30, 10, 30, 10};
        drive_period(n1);
        drive(1'b1, 1'b0, 3);
        ea.push_back(model(n1));
        drive(1'b1, 1'b1, 3);
        drive(1'b0, 1'b1, 10);
        drive(1'b0, 1'b0, 10);
        check("ovl_fault_set", ifa.shoot_through_fault, 1);
        drive_period(n2);
        drive_period(n2);
        ea.push_back(model(n2));
        drive(1'b0, 1'b0, 5);
        compare("ovl", 1'b0);
        check("ovl_fault_sticky", ifa.shoot_through_fault, 1);
        fc = 1'b1;
        @(negedge clk);
        fc = 1'b0;
        @(negedge clk);
        check("ovl_fault_cleared", ifa.shoot_through_fault, 0);
        drive(1'b1, 1'b1, 4);
        fc = 1'b1;
        drive(1'b1, 1'b1, 3);
        check("ovl_clear_vs_overlap", ifa.shoot_through_fault, 1);
        fc = 1'b0;
        drive(1'b0, 1'b0, 5);

        // Stall: hs held high 2000 cycles
        do_reset();
        n1 = '{30, 12, 40, 18};
        n2 = '{35, 10, 45, 10};
        n3 = '{20, 8, 60, 12};
        n4 = '{40, 15, 30, 15};
        drive_period(n1);
        m1 = model(n1);
        ea.push_back(m1);
        drive(1'b1, 1'b0, 990);
        check("stall_before", ifa.stalled, 0);
        drive(1'b1, 1'b0, 20);
        check("stall_set", ifa.stalled, 1);
        check("stall_hold_hs", ifa.tick_count_highside_output, m1.hs);
        check("stall_hold_per", ifa.tick_count_period_output, m1.per);
        drive(1'b1, 1'b0, 990);
        drive(1'b0, 1'b0, 5);
        check("stall_cleared", ifa.stalled, 0);
        drive_period(n2);
        drive_period(n3);
        ea.push_back(model(n2));
        drive_period(n4);
        ea.push_back(model(n3));
        drive(1'b0, 1'b0, 5);
        compare("stall", 1'b0);

        // Saturation on the long-timeout instance; the default instance stalls instead
        do_reset();
        satp = '{1500, 10, 20, 10};
        drive_period(n1);
        drive_period(satp);
        drive_period(n2);
        drive_period(n3);
        drive(1'b0, 1'b0, 5);
        ea.push_back(model(n1));
        ea.push_back(model(n2));
        eb.push_back(model(n1));
        eb.push_back(model(satp));
        eb.push_back(model(n2));
        compare("sat_a", 1'b0);
        compare("sat_b", 1'b1);

        // Reset during LS_ON clears outputs at once; two rises needed afterwards
        do_reset();
        drive_period(n1);
        drive(1'b1, 1'b0, 30);
        drive(1'b0, 1'b0, 12);
        drive(1'b0, 1'b1, 20);
        check("mid_pre_hs", ifa.tick_count_highside_output, model(n1).hs);
        #3 rst = 1'b1;
        #1 check_zero_outputs("mid_reset");
        @(negedge clk);
        ls = 1'b0;
        clear_queues();
        rst = 1'b0;
        drive(1'b0, 1'b0, 5);
        drive_period(n2);
        check("mid_no_valid_first", qa.size(), 0);
        drive_period(n3);
        drive_period(n4);
        ea.push_back(model(n2));
        ea.push_back(model(n3));
        drive(1'b0, 1'b0, 5);
        compare("mid", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
